// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers; MTHI/MTLO write directly.
// Latency: start accepted at edge E0, HI/LO written and done pulsed at E0+WIDTH+1; MTHI/MTLO take effect on E0.
// Backpressure: busy is high while an operation runs; start is ignored while busy, abort cancels without a write.
module mips_cpu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    state_t state, state_nxt;

    // Datapath: r_hi is the running high half / partial remainder, r_lo the
    // multiplier being consumed / dividend shifting out while quotient shifts in.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    cnt;
    logic             is_mul;
    logic             lo_neg;
    logic             hi_neg;

    // Control strobes from the output decoder
    logic accept;
    logic step;
    logic commit;
    logic mt_hi;
    logic mt_lo;

    // Operand decode and magnitude extraction for the accept cycle
    logic             op_mul;
    logic             op_div;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {r_hi, r_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    // Sign correction of the unsigned result applied on the FIX cycle
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign prod     = {r_hi, r_lo};
    assign prod_fix = lo_neg ? -prod : prod;
    assign quo_fix  = lo_neg ? -r_lo : r_lo;
    assign rem_fix  = hi_neg ? -r_hi : r_hi;
    assign res_hi   = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
    assign res_lo   = is_mul ? prod_fix[WIDTH-1:0]       : quo_fix;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: abort wins over iteration and over the FIX write
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && (op_mul || op_div)) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                  state_nxt = ST_IDLE;
                else if (cnt == LAST_STEP)  state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: status and datapath strobes
    always_comb begin
        busy   = (state != ST_IDLE);
        accept = (state == ST_IDLE) && start && (op_mul || op_div);
        mt_hi  = (state == ST_IDLE) && start && (op == OP_MTHI);
        mt_lo  = (state == ST_IDLE) && start && (op == OP_MTLO);
        step   = (state == ST_RUN) && !abort;
        commit = (state == ST_FIX) && !abort;
    end

    // Iterative datapath: capture magnitudes and signs, then one bit per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            lo_neg <= 1'b0;
            hi_neg <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            r_hi   <= '0;
            is_mul <= op_mul;
            hi_neg <= op_div && a_neg;
            if (op_mul) begin
                opnd   <= a_abs;
                r_lo   <= b_abs;
                lo_neg <= a_neg ^ b_neg;
            end else begin
                opnd   <= b_abs;
                r_lo   <= a_abs;
                // Divide by zero must leave an all-ones quotient whatever the dividend sign.
                lo_neg <= (a_neg ^ b_neg) && (b != '0);
            end
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_mul) begin
                r_hi <= mul_sum[WIDTH:1];
                r_lo <= {mul_sum[0], r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], div_ge};
            end
        end
    end

    // HI/LO architectural registers: result commit or direct move
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (mt_hi) begin
            hi <= a;
        end else if (mt_lo) begin
            lo <= a;
        end
    end

    // Completion pulse coincides with the HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done <= 1'b0;
        else       done <= commit;
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed bench for the multiply/divide unit at WIDTH=32.
// Inputs are driven on the falling edge or just after the rising edge; outputs sampled 1ns after the rising edge.
// Each comparison is an immediate assertion that counts and reports its own failure.
module tb_mips_cpu_muldiv_seq;

    localparam int W = 32;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    mips_cpu_muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one MULT/DIV, scramble the operands after capture, and check latency, result and pulse width.
    task automatic do_muldiv(input string tag, input logic [5:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int lat;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check({tag, ".busy_start"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(W + 1));
        check({tag, ".busy_done"}, 64'(busy), 64'd0);
        check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 6'd0;
        a     = '0;
        b     = '0;
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply
        do_muldiv("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_muldiv("mult_neg6x7", OP_MULT, 32'hFFFF_FFFA, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        do_muldiv("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_muldiv("multu_2p32", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        do_muldiv("mult_3xm1", OP_MULT, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Divide
        do_muldiv("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_muldiv("div_7dm2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_muldiv("divu_10d3", OP_DIVU, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003);
        do_muldiv("divu_by0", OP_DIVU, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFF);
        do_muldiv("div_neg_by0", OP_DIV, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        do_muldiv("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI then MTLO on back-to-back cycles
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("mthi.hi", 64'(hi), 64'h1234);
        check("mthi.busy", 64'(busy), 64'd0);
        check("mthi.done", 64'(done), 64'd0);
        @(negedge clk);
        op = OP_MTLO;
        a  = 32'h0000_5678;
        @(posedge clk);
        #1;
        check("mtlo.lo", 64'(lo), 64'h5678);
        check("mtlo.hi", 64'(hi), 64'h1234);
        check("mtlo.busy", 64'(busy), 64'd0);
        check("mtlo.done", 64'(done), 64'd0);

        // Preload HI=AA, LO=BB, then abort a DIVU in the middle
        @(negedge clk);
        op = OP_MTHI;
        a  = 32'h0000_00AA;
        @(negedge clk);
        op = OP_MTLO;
        a  = 32'h0000_00BB;
        @(negedge clk);
        op = OP_DIVU;
        a  = 32'd10;
        b  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort.busy_start", 64'(busy), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.hi", 64'(hi), 64'hAA);
        check("abort.lo", 64'(lo), 64'hBB);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort.no_done", 64'(pulses), 64'd0);
        check("abort.hi_kept", 64'(hi), 64'hAA);

        // Start with abort in IDLE, start held while busy with changing operands
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        op    = OP_DIVU;
        a     = 32'd10;
        b     = 32'd3;
        @(posedge clk);
        #1;
        abort = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        check("held.busy", 64'(busy), 64'd1);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        start = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("held.pulses", 64'(pulses), 64'd1);
        check("held.hi", 64'(hi), 64'd1);
        check("held.lo", 64'(lo), 64'd3);
        check("held.busy_end", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'h0000_0005;
        b     = 32'h0000_0006;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("areset.busy", 64'(busy), 64'd0);
        check("areset.done", 64'(done), 64'd0);
        check("areset.hi", 64'(hi), 64'd0);
        check("areset.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Unit is usable again after reset
        do_muldiv("post_reset_mult", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
